// File: rtl/cov_pkg.sv
// Shared definitions for the covariance accumulator.
//   DW_DEF / N_LOG2_DEF : default product width and log2 frame length
//   NTERM               : number of unique covariance terms (upper triangle of 4x4)
//   accw()              : accumulator width needed to sum a full frame without overflow
//   state_t             : frame FSM states
package cov_pkg;

  localparam int DW_DEF     = 16;
  localparam int N_LOG2_DEF = 7;
  localparam int NTERM      = 10;

  // A frame of 2^n products of dw bits needs n extra bits of headroom.
  function automatic int accw(input int dw, input int n);
    return dw + n;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cov_accum_if.sv
// Sample/result bus of the covariance accumulator.
//   master : producer/consumer side -- drives in_valid, X*, out_ready
//   slave  : accumulator side       -- drives in_ready, out_valid, C*, sample_cnt
interface cov_accum_if
  import cov_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    C11, C12, C13, C14, C22, C23, C24, C33, C34, C44;
  logic [N_LOG2-1:0]       sample_cnt;

  modport master (
    output in_valid, X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4, out_ready,
    input  in_ready, out_valid, C11, C12, C13, C14, C22, C23, C24, C33, C34, C44, sample_cnt
  );

  modport slave (
    input  in_valid, X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4, out_ready,
    output in_ready, out_valid, C11, C12, C13, C14, C22, C23, C24, C33, C34, C44, sample_cnt
  );

endinterface

// File: rtl/cov_acc_lane.sv
// One covariance lane: frame accumulator, scale-by-frame-length and held output.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the accumulator (frame abort or result consumed)
//   add_en     : add product into the accumulator
//   last       : this add completes the frame; load the scaled result
//   product    : signed product input (DW bits)
//   cov        : signed covariance term, held until the next frame completes
// Build option: COV_ROUND_EN selects round-half-up instead of floor scaling.
module cov_acc_lane
  import cov_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 add_en,
  input  logic                 last,
  input  logic signed [DW-1:0] product,
  output logic signed [DW-1:0] cov
);

  localparam int ACCW = accw(DW, N_LOG2);

  logic signed [ACCW-1:0] acc_p0;
  logic signed [ACCW-1:0] sum;
  logic signed [DW-1:0]   cov_p1;

  // Divide by the frame length. The rounding offset is below 2^N_LOG2, so
  // the result still lands inside the DW range.
  function automatic logic signed [DW-1:0] scale(input logic signed [ACCW-1:0] s);
    logic signed [ACCW-1:0] t;
`ifdef COV_ROUND_EN
    t = s + $signed(ACCW'(1) << (N_LOG2 - 1));
`else
    t = s;
`endif
    t = t >>> N_LOG2;
    return t[DW-1:0];
  endfunction

  assign sum = acc_p0 + $signed({{N_LOG2{product[DW-1]}}, product});

  // Stage p0: accumulate; stage p1: scaled result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cov_p1 <= '0;
    end else begin
      if (clear)       acc_p0 <= '0;
      else if (add_en) acc_p0 <= sum;
      if (last)        cov_p1 <= scale(sum);
    end
  end

  assign cov = cov_p1;

endmodule

// File: rtl/cov_accum.sv
// Covariance accumulator: sums the ten centred-sample products over a frame
// of 2^N_LOG2 accepted samples and presents the scaled upper triangle of the
// 4x4 covariance matrix under a valid/ready handshake.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous frame abort (clears accumulators/count, back to IDLE)
//   bus   : cov_accum_if.slave -- in_valid/in_ready + X*, out_valid/out_ready + C*, sample_cnt
// Build option: COV_ROUND_EN (see cov_acc_lane) selects round-half-up scaling.
module cov_accum
  import cov_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int N_LOG2 = N_LOG2_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  cov_accum_if.slave  bus
);

  localparam logic [N_LOG2-1:0] CNT_LAST = '1;

  state_t              state_q, state_d;
  logic [N_LOG2-1:0]   cnt_q, cnt_d;
  logic                accept;
  logic                lane_clear, lane_add, lane_last;
  logic signed [DW-1:0] prod [NTERM];
  logic signed [DW-1:0] cov  [NTERM];

  // in_ready depends on state only, never on out_ready.
  assign bus.in_ready   = (state_q != DONE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.sample_cnt = cnt_q;
  assign accept         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_clear = 1'b0;
    lane_add   = 1'b0;
    lane_last  = 1'b0;
    if (clr) begin
      // Abort wins in every state; a same-cycle sample is dropped.
      state_d    = IDLE;
      cnt_d      = '0;
      lane_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            lane_add = 1'b1;
            cnt_d    = N_LOG2'(1);
            state_d  = ACC;
          end
        end
        ACC: begin
          if (accept) begin
            lane_add = 1'b1;
            cnt_d    = cnt_q + N_LOG2'(1);   // wraps to 0 on the frame's last sample
            if (cnt_q == CNT_LAST) begin
              lane_last = 1'b1;
              state_d   = DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d    = IDLE;
            lane_clear = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign prod[0] = bus.X1X1;
  assign prod[1] = bus.X1X2;
  assign prod[2] = bus.X1X3;
  assign prod[3] = bus.X1X4;
  assign prod[4] = bus.X2X2;
  assign prod[5] = bus.X2X3;
  assign prod[6] = bus.X2X4;
  assign prod[7] = bus.X3X3;
  assign prod[8] = bus.X3X4;
  assign prod[9] = bus.X4X4;

  for (genvar i = 0; i < NTERM; i++) begin : g_lane
    cov_acc_lane #(
      .DW     (DW),
      .N_LOG2 (N_LOG2)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (lane_clear),
      .add_en  (lane_add),
      .last    (lane_last),
      .product (prod[i]),
      .cov     (cov[i])
    );
  end

  assign bus.C11 = cov[0];
  assign bus.C12 = cov[1];
  assign bus.C13 = cov[2];
  assign bus.C14 = cov[3];
  assign bus.C22 = cov[4];
  assign bus.C23 = cov[5];
  assign bus.C24 = cov[6];
  assign bus.C33 = cov[7];
  assign bus.C34 = cov[8];
  assign bus.C44 = cov[9];

endmodule

// File: tb/tb_cov_accum.sv
// Self-checking bench for cov_accum: randomized stimulus against a
// frame-level reference model, plus literal expectations for known frames.
module tb_cov_accum;
  import cov_pkg::*;

  localparam int DW    = 16;
  localparam int N     = 7;
  localparam int FRAME = 1 << N;
  localparam int NT    = 10;
`ifdef COV_ROUND_EN
  localparam longint ONES_EXP = 1;
`else
  localparam longint ONES_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DW-1:0] x [NT];
  logic signed [DW-1:0] c [NT];

  int checks = 0;
  int errors = 0;
  int done_cycles = 0;

  // Reference model: frame sums and results
  logic   m_valid;
  int     m_cnt;
  longint m_sum [NT];
  longint m_c   [NT];

  cov_accum_if #(.DW(DW), .N_LOG2(N)) bus ();

  assign bus.in_valid  = in_valid;
  assign bus.out_ready = out_ready;
  assign bus.X1X1 = x[0];
  assign bus.X1X2 = x[1];
  assign bus.X1X3 = x[2];
  assign bus.X1X4 = x[3];
  assign bus.X2X2 = x[4];
  assign bus.X2X3 = x[5];
  assign bus.X2X4 = x[6];
  assign bus.X3X3 = x[7];
  assign bus.X3X4 = x[8];
  assign bus.X4X4 = x[9];
  assign c[0] = bus.C11;
  assign c[1] = bus.C12;
  assign c[2] = bus.C13;
  assign c[3] = bus.C14;
  assign c[4] = bus.C22;
  assign c[5] = bus.C23;
  assign c[6] = bus.C24;
  assign c[7] = bus.C33;
  assign c[8] = bus.C34;
  assign c[9] = bus.C44;

  cov_accum #(.DW(DW), .N_LOG2(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Mean over a frame: floor division, or round-half-up when enabled.
  function automatic longint frame_mean(input longint s);
    longint t;
    t = s;
`ifdef COV_ROUND_EN
    t = t + FRAME / 2;
`endif
    if (t >= 0) return t / FRAME;
    else        return -((-t + FRAME - 1) / FRAME);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_cnt   <= 0;
      for (int i = 0; i < NT; i++) begin
        m_sum[i] <= 0;
        m_c[i]   <= 0;
      end
    end else if (clr) begin
      m_valid <= 1'b0;
      m_cnt   <= 0;
      for (int i = 0; i < NT; i++) m_sum[i] <= 0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        for (int i = 0; i < NT; i++) m_sum[i] <= 0;
      end
    end else if (in_valid) begin
      if (m_cnt == FRAME - 1) begin
        m_valid <= 1'b1;
        m_cnt   <= 0;
        for (int i = 0; i < NT; i++) begin
          m_c[i]   <= frame_mean(m_sum[i] + longint'(x[i]));
          m_sum[i] <= 0;
        end
      end else begin
        m_cnt <= m_cnt + 1;
        for (int i = 0; i < NT; i++) m_sum[i] <= m_sum[i] + longint'(x[i]);
      end
    end
  end

  // Compare every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid) done_cycles++;
      check("out_valid", longint'(bus.out_valid), longint'(m_valid));
      check("in_ready", longint'(bus.in_ready), longint'(!m_valid));
      check("sample_cnt", longint'(bus.sample_cnt), longint'(m_cnt));
      for (int i = 0; i < NT; i++) check($sformatf("C[%0d]", i), longint'(c[i]), m_c[i]);
    end
  end

  task automatic rand_x();
    for (int i = 0; i < NT; i++) x[i] = DW'($urandom);
  endtask

  task automatic drive_sample(input int pat, input int k, input int n);
    case (pat)
      0: for (int i = 0; i < NT; i++) x[i] = 16'sd256;
      1: begin
        for (int i = 0; i < NT; i++) x[i] = '0;
        x[1] = -16'sd3;
      end
      2: begin
        for (int i = 0; i < NT; i++) x[i] = '0;
        x[0] = (k == n - 1) ? 16'sd0 : 16'sd1;
      end
      3: begin
        rand_x();
        x[0] = 16'sd32767;
        x[4] = -16'sd32768;
      end
      4: for (int i = 0; i < NT; i++) x[i] = 16'sd10;
      default: rand_x();
    endcase
  endtask

  // Offer samples until n have been accepted (bounded).
  task automatic send(input int n, input int pat, input bit gaps);
    int got;
    int budget;
    got = 0;
    budget = n * 8 + 40;
    while (got < n && budget > 0) begin
      @(posedge clk); #2;
      clr = 1'b0;
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (in_valid) drive_sample(pat, got, n);
      else          rand_x();
      if (in_valid && bus.in_ready) got++;
      budget--;
    end
    check("send_accepts", longint'(got), longint'(n));
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      rand_x();
    end
  endtask

  task automatic release_result();
    @(posedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NT; i++) x[i] = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);
    check("rst_sample_cnt", longint'(bus.sample_cnt), 0);
    check("rst_C11", longint'(c[0]), 0);
    rst_n = 1'b1;

    // Constant 256 on every product
    send(FRAME, 0, 1'b0);
    idle(1);
    check("t1_out_valid", longint'(bus.out_valid), 1);
    check("t1_in_ready", longint'(bus.in_ready), 0);
    for (int i = 0; i < NT; i++) check($sformatf("t1_C[%0d]", i), longint'(c[i]), 256);
    check("t1_model_C11", m_c[0], 256);
    idle(3);
    release_result();

    // X1X2 = -3, others zero
    send(FRAME, 1, 1'b0);
    idle(1);
    check("t2_C12", longint'(c[1]), -3);
    check("t2_C11", longint'(c[0]), 0);
    check("t2_model_C12", m_c[1], -3);
    release_result();

    // 127 ones then a zero on X1X1: floor gives 0, rounding gives 1
    send(FRAME, 2, 1'b0);
    idle(1);
    check("t2b_C11", longint'(c[0]), ONES_EXP);
    check("t2b_model_C11", m_c[0], ONES_EXP);
    release_result();

    // Full-scale positive and negative
    send(FRAME, 3, 1'b1);
    idle(1);
    check("t3_C11", longint'(c[0]), 32767);
    check("t3_C22", longint'(c[4]), -32768);
    check("t3_model_C22", m_c[4], -32768);
    release_result();

    // Hold in DONE for 20 cycles with random traffic
    send(FRAME, 5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      in_valid = 1'(($urandom & 1));
      rand_x();
    end
    check("t4_hold_in_ready", longint'(bus.in_ready), 0);
    check("t4_hold_cnt", longint'(bus.sample_cnt), 0);
    release_result();
    send(FRAME, 4, 1'b0);
    idle(1);
    for (int i = 0; i < NT; i++) check($sformatf("t4_C[%0d]", i), longint'(c[i]), 10);
    release_result();

    // Abort with clr mid-frame; the clr-cycle sample is dropped
    send(60, 5, 1'b0);
    @(posedge clk); #2;
    clr = 1'b1;
    in_valid = 1'b1;
    rand_x();
    @(posedge clk); #2;
    clr = 1'b0;
    in_valid = 1'b0;
    check("t5_clr_cnt", longint'(bus.sample_cnt), 0);
    send(FRAME, 4, 1'b0);
    idle(1);
    check("t5_C14", longint'(c[3]), 10);
    check("t5_model_C14", m_c[3], 10);
    release_result();

    // Reset mid-frame
    send(60, 5, 1'b0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5r_out_valid", longint'(bus.out_valid), 0);
    check("t5r_cnt", longint'(bus.sample_cnt), 0);
    check("t5r_C11", longint'(c[0]), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    send(FRAME, 5, 1'b1);
    idle(1);
    release_result();

    // Two back-to-back frames with gaps and out_ready held high
    out_ready = 1'b1;
    idle(1);
    done_cycles = 0;
    send(FRAME, 5, 1'b1);
    send(FRAME, 5, 1'b1);
    idle(4);
    check("t6_done_cycles", longint'(done_cycles), 2);
    out_ready = 1'b0;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cov_accum.md
# cov_accum

Covariance accumulator for the whitening stage. Consumes the ten unique centred-sample products (X1X1 … X4X4) produced each cycle by the whitening multiplier, sums each over a frame of 2^N_LOG2 accepted samples, and divides by the frame length to produce the upper triangle of the 4×4 covariance matrix. The results are held under a valid/ready handshake for the eigen-decomposition stage that follows.

## Interface
Parameters:
- DW, 16: width of product inputs and covariance outputs, signed.
- N_LOG2, 7: log2 of the frame length; default frame is 128 samples.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- clr  in  1  synchronous frame abort. Clears the accumulators and count and returns to IDLE.
- in_valid  in  1  product set on the X inputs is valid this cycle.
- in_ready  out  1  block accepts a product set this cycle.
- X1X1, X1X2, X1X3, X1X4, X2X2, X2X3, X2X4, X3X3, X3X4, X4X4  in  DW each  signed products.
- out_valid  out  1  covariance results are valid and held.
- out_ready  in  1  downstream consumes the results.
- C11, C12, C13, C14, C22, C23, C24, C33, C34, C44  out  DW each  signed covariance terms.
- sample_cnt  out  N_LOG2  number of samples accepted in the current frame.

## Operation
- States: IDLE, ACC, DONE.
- Accept occurs when in_valid && in_ready.
- in_ready = (state != DONE). It is derived from state only, with no combinational path from out_ready.
- Accumulators are ACCW = DW+N_LOG2 bits, signed. On each accept, every accumulator adds its sign-extended product. Overflow cannot occur.
- IDLE: on an accept, accumulators load the current products, sample_cnt becomes 1, and the state moves to ACC.
- ACC: on an accept, accumulators add and sample_cnt increments.
  - On the accept that completes the frame (sample_cnt == 2^N_LOG2−1), each Cxx output register loads (acc + product) >>> N_LOG2, using an arithmetic shift.
  - On that same accept, sample_cnt wraps to 0 and the state moves to DONE.
- DONE: outputs are held stable and out_valid = 1. Inputs are ignored.
  - On out_ready, the state moves to IDLE and the accumulators clear.
  - out_valid deasserts the next cycle. The Cxx outputs keep their last value until the next frame completes.
- clr has priority over everything else in every state.
  - Clears the accumulators and sample_cnt, and sets out_valid = 0. State goes to IDLE.
  - Cxx outputs are not cleared.
  - A sample presented in the same cycle as clr is discarded.
- A gap (in_valid = 0) inside ACC holds all state. Frames need not be contiguous.

## Timing
- Reset values: state IDLE, accumulators 0, sample_cnt 0, out_valid 0, all Cxx 0. in_ready is 1 immediately after reset (state is IDLE).
- Latency: out_valid rises on the edge that accepts the final sample. It is observable in the first cycle after the last accept.
- Throughput: one sample per cycle in IDLE/ACC. A minimum of one bubble cycle per frame, since in DONE in_ready = 0.
- Back-to-back frames: if out_ready is held at 1, DONE lasts exactly one cycle. The next frame's first sample is accepted the following cycle.
- Reset asserted mid-frame: everything returns to reset values immediately. No partial result is emitted.

## Configuration
- COV_ROUND_EN defined: the scaling adds 2^(N_LOG2−1) before the arithmetic shift, giving round-half-up. The result still fits in DW bits because the added term is smaller than the frame length.
- COV_ROUND_EN undefined: plain arithmetic shift, i.e. floor division.

## Structure
- Package cov_pkg holds:
  - DW and N_LOG2 defaults;
  - the ACCW derivation;
  - the state enum type {IDLE, ACC, DONE}.
- Sub-module cov_acc_lane: one accumulator plus the scale/round and output register. It is instantiated 10 times.
  - Inputs: clk, rst_n, clear, add_en, last, product.
  - Output: covariance term.
- The top level owns the FSM, sample_cnt and the handshake.

## Test plan
- Reset, then 128 accepts with all products = 256 → out_valid after the 128th sample, all Cxx = 256, in_ready = 0 while out_valid is high.
- 128 accepts with X1X2 = −3 and the others 0 → C12 = −3; all other Cxx = 0. With 127 × 1 and one × 0 on X1X1: C11 = 0 without COV_ROUND_EN and 1 with it.
- Full scale: 128 samples of 32767 and of −32768 → C11 = 32767 and C22 = −32768, with no wrap, both with and without COV_ROUND_EN.
- out_ready held low for 20 cycles in DONE with random in_valid → outputs stable, in_ready = 0, no samples counted. Raising out_ready → IDLE next cycle, and the next frame's accumulation starts from 0.
- Pass 60 samples, pulse clr together with in_valid, then run a 128-sample frame of value 10 → result 10 (the first 60 samples and the clr-cycle sample are discarded). Repeat with rst_n low mid-frame → reset values, then a correct next frame.
- Random in_valid gaps across two frames with out_ready = 1 → results match a reference model, and DONE lasts one cycle per frame.
